// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan path.
// Glyphs are active-low {g,f,e,d,c,b,a}; the DP bit is prepended by the decoder.
package seg_pkg;

    localparam logic [3:0] SEG_CODE_DASH  = 4'd10;
    localparam logic [3:0] SEG_CODE_BLANK = 4'd15;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    localparam logic [7:0] AN_OFF   = 8'hFF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_LAMP = 8'h00;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

    function automatic logic [7:0] an_sel(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display word in, board pins out, for the scan driver.
interface seg_scan_driver_if;

    logic [39:0] eight_segment;
    logic        lamp_test;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    modport master (
        output eight_segment,
        output lamp_test,
        input  an,
        input  seg,
        input  frame_start
    );

    modport slave (
        input  eight_segment,
        input  lamp_test,
        output an,
        output seg,
        output frame_start
    );

endinterface

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Digit code to active-low {dp,g,f,e,d,c,b,a}.
// Codes 11..15 render blank so upstream can suppress digits.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp_n,
    output logic [7:0] seg
);

    logic [6:0] glyph;

    always_comb begin
        glyph = GLYPH_BLANK;
        unique case (code)
            4'd0:          glyph = GLYPH_0;
            4'd1:          glyph = GLYPH_1;
            4'd2:          glyph = GLYPH_2;
            4'd3:          glyph = GLYPH_3;
            4'd4:          glyph = GLYPH_4;
            4'd5:          glyph = GLYPH_5;
            4'd6:          glyph = GLYPH_6;
            4'd7:          glyph = GLYPH_7;
            4'd8:          glyph = GLYPH_8;
            4'd9:          glyph = GLYPH_9;
            SEG_CODE_DASH: glyph = GLYPH_DASH;
            default:       glyph = GLYPH_BLANK;
        endcase
    end

    assign seg = {dp_n, glyph};

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit common-anode scanner with per-slot dead time.
// The word is snapshotted at the top of each frame so digits never tear.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.slave   bus
);

    localparam int MAX_CYCLES =
        (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW =
        (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [39:0]   snap;
    logic [7:0]    an_q;
    logic [7:0]    seg_q;
    logic          fs_q;

    logic          latch;
    logic [3:0]    code;
    logic          dp_n;
    logic [7:0]    glyph_seg;

    assign latch = (state == S_BLANK) && (idx == 3'd7) && (cnt == '0);
    assign code  = snap[{idx, 2'b00} + 6'd8 +: 4];
    assign dp_n  = snap[idx];

    bcd_to_seg u_dec (
        .code (code),
        .dp_n (dp_n),
        .seg  (glyph_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BLANK;
            cnt   <= '0;
            idx   <= 3'd7;
            snap  <= '0;
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= latch;
            if (latch)
                snap <= bus.eight_segment;

            // Pins follow the state one cycle late, glitch-free.
            unique case (state)
                S_ON: begin
                    an_q  <= an_sel(idx);
                    seg_q <= bus.lamp_test ? SEG_LAMP : glyph_seg;
                end
                default: begin
                    an_q  <= AN_OFF;
                    seg_q <= SEG_OFF;
                end
            endcase

            unique case (state)
                S_ON: begin
                    if (cnt == DIGIT_LAST) begin
                        state <= S_BLANK;
                        cnt   <= '0;
                        idx   <= idx - 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == BLANK_LAST) begin
                        state <= S_ON;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed frame-by-frame bench for seg_scan_driver (slot 6, frame 48).
// Each frame is checked cycle by cycle against hand-computed glyph tables.
module tb_seg_scan_driver;

    localparam int DC    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = 8 * SLOT;

    localparam logic [39:0] W_GLYPH = 40'h12A34A56FF;
    localparam logic [63:0] E_GLYPH = 64'hF9A4BFB099BF9282;
    localparam logic [39:0] W_DP    = 40'h00000000EA;
    localparam logic [63:0] E_DP    = 64'hC0C0C040C040C040;
    localparam logic [39:0] W_BLK   = 40'hBCDEFBCD7E;
    localparam logic [63:0] E_BLK   = 64'h7FFFFFFFFFFFFF7F;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Caller sits on the negedge just before the frame_start edge.
    task automatic check_frame(input string tag,
                               input logic [63:0] e,
                               input logic lt);
        int d;
        logic [16:0] want;
        for (int o = 0; o < FRAME; o++) begin
            d = 7 - o / SLOT;
            @(negedge clk);
            if (o % SLOT < BC)
                want = {o == 0, 16'hFFFF};
            else
                want = {1'b0, ~(8'b1 << d), lt ? 8'h00 : e[8*d +: 8]};
            check($sformatf("%s[%0d]", tag, o),
                  {47'd0, bus.frame_start, bus.an, bus.seg},
                  {47'd0, want});
        end
    endtask

    initial begin
        int run_on;
        int run_off;
        bus.eight_segment = W_GLYPH;
        bus.lamp_test     = 1'b0;
        #1 rst = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_an", {56'd0, bus.an}, 64'hFF);
        check("rst_seg", {56'd0, bus.seg}, 64'hFF);
        check("rst_fs", {63'd0, bus.frame_start}, 64'd0);

        rst = 1'b0;
        check_frame("glyph", E_GLYPH, 1'b0);

        bus.eight_segment = W_DP;
        check_frame("dp", E_DP, 1'b0);

        bus.eight_segment = W_BLK;
        check_frame("blank", E_BLK, 1'b0);

        bus.eight_segment = W_GLYPH;
        fork
            check_frame("tear_old", E_GLYPH, 1'b0);
            begin
                repeat (28) @(negedge clk);
                bus.eight_segment = W_DP;
            end
        join
        check_frame("tear_new", E_DP, 1'b0);

        bus.lamp_test = 1'b1;
        check_frame("lamp", E_DP, 1'b1);
        bus.lamp_test = 1'b0;

        repeat (16) @(negedge clk);
        check("mid_an", {56'd0, bus.an}, 64'hDF);
        #2 rst = 1'b1;
        #1;
        check("async_an", {56'd0, bus.an}, 64'hFF);
        check("async_seg", {56'd0, bus.seg}, 64'hFF);
        @(negedge clk);
        rst = 1'b0;
        check_frame("rst_frame", E_DP, 1'b0);

        run_on  = 0;
        run_off = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check("onehot",
                  {63'd0, (bus.an == 8'hFF) || $onehot(~bus.an)}, 64'd1);
            if (bus.an == 8'hFF) begin
                if (run_on > 0)
                    check("lit_len", 64'(run_on), 64'(DC));
                run_on = 0;
                run_off++;
            end else begin
                if (run_off > 0)
                    check("blank_len", 64'(run_off), 64'(BC));
                run_off = 0;
                run_on++;
            end
            bus.eight_segment = {$urandom, 8'($urandom)};
            bus.lamp_test     = 1'($urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
